// File: rtl/coproc_issuer.sv
// coproc_issuer: buffers host instructions in a small FIFO and issues them one at
// a time to the coprocessor, returning each 16-bit result or reporting a timeout.
module coproc_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      host_valid_i,
  output logic                      host_ready_o,
  input  logic [3:0]                host_opcode_i,
  input  logic [7:0]                host_addr_i,
  input  logic [15:0]               host_data_i,
  output logic [31:0]               instruction_o,
  output logic                      activate_instruction_o,
  input  logic                      cop_done_i,
  input  logic [15:0]               cop_result_i,
  output logic                      res_valid_o,
  output logic [15:0]               res_data_o,
  output logic [3:0]                res_opcode_o,
  output logic                      err_illegal_o,
  output logic                      err_timeout_o,
  output logic                      busy_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 16;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  function automatic logic opcode_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd12);
  endfunction

  // FIFO entries hold the low 28 instruction bits; the top nibble is always zero.
  logic [27:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ready_q;
  state_e        state_q;
  logic [CW-1:0] tmr_q;
  logic [31:0]   instr_q;
  logic          act_q;
  logic          res_valid_q;
  logic [15:0]   res_data_q;
  logic [3:0]    res_op_q;
  logic          err_ill_q;
  logic          err_tmo_q;
  logic          busy_q;

  logic push_req;
  logic push_en;
  logic pop_en;

  always_comb begin
    push_req = host_valid_i & ready_q;
    push_en  = push_req & opcode_legal(host_opcode_i);
    pop_en   = (state_q == S_IDLE) && (count_q != '0);
    count_d  = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      fifo_q[wr_ptr_q] <= {host_data_i, host_addr_i, host_opcode_i};
    end
  end

  // Ready is registered from the next count, so a pop frees space one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      instr_q     <= 32'd0;
      act_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      res_op_q    <= 4'd0;
      err_ill_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      ready_q     <= (count_d < DEPTH_C);
      err_ill_q   <= push_req & ~opcode_legal(host_opcode_i);
      act_q       <= 1'b0;
      res_valid_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (pop_en) begin
            instr_q  <= {4'd0, fifo_q[rd_ptr_q]};
            rd_ptr_q <= rd_ptr_q + AW'(1);
            act_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the expiry cycle still counts as a result.
          if (cop_done_i) begin
            res_data_q  <= cop_result_i;
            res_op_q    <= instr_q[3:0];
            res_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (tmr_q == TMO_LAST) begin
            err_tmo_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign host_ready_o           = ready_q;
  assign instruction_o          = instr_q;
  assign activate_instruction_o = act_q;
  assign res_valid_o            = res_valid_q;
  assign res_data_o             = res_data_q;
  assign res_opcode_o           = res_op_q;
  assign err_illegal_o          = err_ill_q;
  assign err_timeout_o          = err_tmo_q;
  assign busy_o                 = busy_q;
  assign count_o                = count_q;

endmodule

// File: tb/tb_coproc_issuer.sv
// Scoreboard bench for coproc_issuer: a coprocessor responder predicts every
// result/timeout with its arrival cycle; a monitor compares DUT strobes to the queues.
module tb_coproc_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int MODE_FIXED  = 0;
  localparam int MODE_NEVER  = 1;
  localparam int MODE_RANDOM = 2;

  typedef struct {
    bit          tmo;
    logic [3:0]  op;
    logic [15:0] data;
    int          at;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [3:0]  host_opcode;
  logic [7:0]  host_addr;
  logic [15:0] host_data;
  logic [31:0] instruction;
  logic        activate;
  logic        cop_done;
  logic [15:0] cop_result;
  logic        res_valid;
  logic [15:0] res_data;
  logic [3:0]  res_opcode;
  logic        err_illegal;
  logic        err_timeout;
  logic        busy;
  logic [2:0]  count;

  coproc_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i                  (clk),
    .reset_i                (reset),
    .host_valid_i           (host_valid),
    .host_ready_o           (host_ready),
    .host_opcode_i          (host_opcode),
    .host_addr_i            (host_addr),
    .host_data_i            (host_data),
    .instruction_o          (instruction),
    .activate_instruction_o (activate),
    .cop_done_i             (cop_done),
    .cop_result_i           (cop_result),
    .res_valid_o            (res_valid),
    .res_data_o             (res_data),
    .res_opcode_o           (res_opcode),
    .err_illegal_o          (err_illegal),
    .err_timeout_o          (err_timeout),
    .busy_o                 (busy),
    .count_o                (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_issue_q [$];
  logic [31:0] rq [$];
  res_t        exp_res_q [$];
  int          exp_ill_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  int          mode = MODE_NEVER;
  int          fixed_j = 0;
  logic [15:0] fixed_data = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    host_valid = 1'b0;
    while (!host_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("push_ready", host_ready, 1'b1);
    if (host_ready) begin
      host_valid  = 1'b1;
      host_opcode = op;
      host_addr   = a;
      host_data   = d;
      if (op inside {[4'd1:4'd12]}) begin
        exp_issue_q.push_back({4'h0, d, a, op});
        rq.push_back({4'h0, d, a, op});
      end else begin
        exp_ill_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic host_idle();
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_issue_q.size() > 0 || exp_res_q.size() > 0 || exp_ill_q.size() > 0 || busy)
           && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_issue_q.size() + exp_res_q.size() + exp_ill_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_instruction", instruction, 32'h0);
    check("rst_activate", activate, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 16'h0);
    check("rst_res_opcode", res_opcode, 4'h0);
    check("rst_err", {err_illegal, err_timeout}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", host_ready, 1'b1);
    check("rst_count", count, 3'd0);
  endtask

  // Coprocessor model: picks a response delay per issued instruction and predicts the outcome.
  logic [31:0] r_ent;
  int          r_j;
  int          r_pick;
  logic [15:0] r_d;
  bit          r_stray;
  res_t        r_exp;
  initial begin : responder
    cop_done   = 1'b0;
    cop_result = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset && activate && rq.size() > 0) begin
        r_ent   = rq.pop_front();
        r_stray = 1'b0;
        case (mode)
          MODE_FIXED: begin r_j = fixed_j; r_d = fixed_data; end
          MODE_NEVER: begin r_j = TIMEOUT; r_d = 16'h0; end
          default: begin
            r_pick = $urandom_range(0, 99);
            r_d    = 16'($urandom);
            if (r_pick < 20)      r_j = TIMEOUT - 1;
            else if (r_pick < 35) begin r_j = TIMEOUT; r_stray = r_pick[0]; end
            else                  r_j = $urandom_range(0, TIMEOUT - 2);
          end
        endcase
        if (r_j < TIMEOUT) begin
          r_exp.tmo = 1'b0; r_exp.op = r_ent[3:0]; r_exp.data = r_d; r_exp.at = cyc + 2 + r_j;
          exp_res_q.push_back(r_exp);
          repeat (r_j + 1) @(posedge clk);
          #1 cop_done = 1'b1; cop_result = r_d;
          @(posedge clk);
          #1 cop_done = 1'b0; cop_result = 16'($urandom);
        end else begin
          r_exp.tmo = 1'b1; r_exp.op = 4'h0; r_exp.data = 16'h0; r_exp.at = cyc + TIMEOUT + 1;
          exp_res_q.push_back(r_exp);
          if (r_stray) begin
            repeat (TIMEOUT + 1) @(posedge clk);
            #1 cop_done = 1'b1; cop_result = 16'($urandom);
            @(posedge clk);
            #1 cop_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every DUT strobe pops and checks a scoreboard entry.
  res_t        m_e;
  bit          in_flight = 1'b0;
  logic        prev_act = 1'b0;
  logic [31:0] held = 32'h0;
  logic [19:0] last_res = 20'h0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        in_flight = 1'b0;
        prev_act  = 1'b0;
        last_res  = 20'h0;
      end else begin
        if (res_valid || err_timeout) begin
          check("res_tmo_exclusive", res_valid & err_timeout, 1'b0);
          if (exp_res_q.size() == 0) check("unexpected_result", {res_valid, err_timeout}, 2'b00);
          else begin
            m_e = exp_res_q.pop_front();
            check("res_kind_timeout", err_timeout, m_e.tmo);
            check("res_cycle", cyc, m_e.at);
            if (!m_e.tmo) begin
              check("res_data", res_data, m_e.data);
              check("res_opcode", res_opcode, m_e.op);
              last_res = {m_e.op, m_e.data};
            end
          end
          in_flight = 1'b0;
        end
        if (err_illegal) begin
          if (exp_ill_q.size() == 0) check("unexpected_illegal", err_illegal, 1'b0);
          else check("illegal_cycle", cyc, exp_ill_q.pop_front());
        end
        if (activate) begin
          check("act_width", prev_act, 1'b0);
          if (exp_issue_q.size() == 0) check("unexpected_issue", activate, 1'b0);
          else check("issue_instr", instruction, exp_issue_q.pop_front());
          in_flight = 1'b1;
          held      = instruction;
        end else if (in_flight) begin
          check("instr_hold", instruction, held);
        end
        check("res_hold", {res_opcode, res_data}, last_res);
        check("busy", busy, in_flight);
        check("count_max", count <= 3'(DEPTH), 1'b1);
        prev_act = activate;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [3:0] s_op;
  int         s_gap;
  initial begin : stimulus
    reset = 1'b1; host_valid = 1'b0; host_opcode = 4'h0; host_addr = 8'h0; host_data = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values();

    // single issue with fixed latency
    mode = MODE_FIXED; fixed_j = 10; fixed_data = 16'h00AB;
    push(4'd3, 8'h10, 16'h0005);
    host_idle();
    @(negedge clk);
    check("lat_act_early", activate, 1'b0);
    check("lat_count", count, 3'd1);
    @(negedge clk);
    check("lat_act", activate, 1'b1);
    check("lat_instr", instruction, 32'h0000_5103);
    @(negedge clk);
    check("lat_act_drop", activate, 1'b0);
    drain(100);
    check("single_res_data", res_data, 16'h00AB);
    check("single_res_op", res_opcode, 4'd3);

    // stray completion while idle
    @(posedge clk); #1 cop_done = 1'b1; cop_result = 16'h1234;
    @(posedge clk); #1 cop_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_res_data", res_data, 16'h00AB);

    // illegal opcodes
    push(4'd0, 8'h01, 16'h1111);
    push(4'd13, 8'h02, 16'h2222);
    push(4'd15, 8'h03, 16'h3333);
    host_idle();
    repeat (3) @(negedge clk);
    check("illegal_count", count, 3'd0);
    check("illegal_pulses", exp_ill_q.size(), 0);

    // fill with a silent coprocessor; every entry times out in order
    mode = MODE_NEVER;
    for (int i = 0; i < 5; i++) push(4'(i + 1), 8'(8'h20 + i), 16'(16'hA000 + i));
    host_idle();
    @(negedge clk);
    check("fill_count", count, 3'd4);
    check("fill_ready", host_ready, 1'b0);
    drain(500);

    // done on the exact expiry cycle, then the quickest completion
    mode = MODE_FIXED; fixed_j = TIMEOUT - 1; fixed_data = 16'hBEEF;
    push(4'd1, 8'h44, 16'h0);
    host_idle();
    drain(100);
    fixed_j = 0; fixed_data = 16'h5A5A;
    push(4'd12, 8'hFF, 16'hFFFF);
    host_idle();
    drain(100);

    // randomized traffic
    mode = MODE_RANDOM;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 15) s_op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(13, 15));
      else s_op = 4'($urandom_range(1, 12));
      push(s_op, 8'($urandom), 16'($urandom));
      s_gap = $urandom_range(0, 3);
      if (s_gap > 0) begin
        host_idle();
        repeat (s_gap - 1) @(posedge clk);
      end
    end
    host_idle();
    drain(4000);

    // reset while an instruction is in WAIT with three more queued
    mode = MODE_NEVER;
    for (int i = 0; i < 4; i++) push(4'd2, 8'(i), 16'(16'h0100 + i));
    host_idle();
    repeat (5) @(negedge clk);
    check("pre_reset_count", count, 3'd3);
    @(posedge clk); #1 reset = 1'b1;
    exp_issue_q.delete(); rq.delete(); exp_res_q.delete(); exp_ill_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1 cop_done = 1'b1; cop_result = 16'hDEAD;
    @(posedge clk); #1 cop_done = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_count", count, 3'd0);
    check("post_reset_res", res_data, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
